gray_fifo_drain: RTL and testbench
==================================

// Module: gray_fifo_drain
// PURPOSE
//  Downstream consumer of simple_bin2gray. Bus master on its enable/addr/read/write port.
//  Polls CTL_STAT (addr 3) and pops gray-coded words from the FIFO (addr 0).
//  Converts each word back to binary and presents it on a valid/ready stream.
//  Sees FIFO overflow/underflow flags, issues a clear, counts the error.
// PARAMETERS
//  DW        8   data width; equals the FIFO word width
//  RD_LAT    1   cycles from the addr-0 read strobe to valid bus_rdata (0 or 1)
//  POLL_GAP  2   idle cycles between status polls while the FIFO is empty (>=0)
// PORTS
//  clk        in   1    clock; all logic on the rising edge
//  rst        in   1    synchronous reset, active-high
//  bus_enable out  1    bus enable to the bin2gray block
//  bus_addr   out  2    0=FIFO data, 3=CTL_STAT
//  bus_read   out  1    read strobe
//  bus_write  out  1    write strobe (clear only)
//  bus_wdata  out  DW   write data; 8'h10 on clear, else 0
//  bus_rdata  in   DW   read data; CTL_STAT is combinational, FIFO data per RD_LAT
//  m_valid    out  1    output word valid
//  m_ready    in   1    downstream accepts when m_valid&&m_ready
//  m_data     out  DW   binary word
//  err_cnt    out  8    count of clears issued, saturates at 8'hFF
//  busy       out  1    FSM not in IDLE, or output buffer not empty
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - All bus outputs 0. m_valid=0, m_data=0, err_cnt=0, busy=0.
//   - FSM to IDLE, output buffer flushed, gap counter cleared.
//   - Reset mid-transaction drops any in-flight word; no partial output.
//  All bus outputs are registered. One bus access per cycle at most.
//  Word decode: b[DW-1]=g[DW-1]; b[i]=b[i+1]^g[i]. Pure function, no rounding or width change.
//  Output buffer: 2-entry FIFO (skid) feeding m_*.
//   - m_data and m_valid come from the head entry.
//   - Holds while m_valid&&!m_ready; m_data stays stable while stalled.
//   - credit = 2 - occupancy - inflight. A pop is issued only if credit>0.
//  FSM states:
//   IDLE : credit>0 and gap counter==0 -> STAT. Else decrement the gap counter if nonzero.
//   STAT : drive enable=1, addr=3, read=1. Sample bus_rdata the same cycle.
//          - rdata[3]|rdata[2] (underflow|overflow) -> CLR.
//          - else rdata[0] (empty) -> IDLE, gap counter := POLL_GAP.
//          - else -> POP.
//   POP  : drive enable=1, addr=0, read=1 for exactly one cycle; inflight=1.
//          - RD_LAT=0: capture bus_rdata this cycle -> STAT if credit remains, else IDLE.
//          - RD_LAT=1: -> WAIT.
//   WAIT : bus idle. Capture bus_rdata, decode, push to buffer, inflight=0.
//          - -> STAT if credit>0, else IDLE.
//   CLR  : drive enable=1, addr=3, write=1, wdata=8'h10 for one cycle.
//          - err_cnt+=1 unless already 8'hFF. -> IDLE with gap counter := POLL_GAP.
//  Boundary rules:
//   - Full FIFO (rdata[1]) is not an error. Drain proceeds normally.
//   - Buffer full (credit==0): no read is issued. FIFO words are never lost to backpressure.
//   - A push and a pop on the buffer in the same cycle are both honoured; occupancy is unchanged.
//   - Error flags take priority over data. Any words still in the FIFO after a clear are treated as discarded.
//   - Back-to-back pops with m_ready=1: one word per 2 cycles (RD_LAT=0) or per 3 cycles (RD_LAT=1).
//   - bus_read and bus_write are never asserted together.
// TESTING
//  T1 reset: rst=1 for 2 cycles, mid-WAIT -> all outputs 0, state IDLE, no m_valid afterwards.
//  T2 decode: FIFO holds gray 0x0C, 0x80, 0x00 with m_ready=1 -> m_data 0x08, 0xFF, 0x00 in order.
//  T3 backpressure: 5 words queued, m_ready=0 for 20 cycles.
//     -> exactly 2 reads issued, m_data stable. On release all 5 words arrive, none lost.
//  T4 empty poll: FIFO empty, POLL_GAP=2 -> addr-3 reads every 4th cycle, no addr-0 reads.
//  T5 overflow: write 9 words into a full FIFO.
//     -> one addr-3 write of 8'h10, err_cnt=1. After 256 such events err_cnt holds 8'hFF.
//  T6 throughput: RD_LAT=1, 4 words queued, m_ready=1 -> m_valid pulses spaced 3 cycles apart.

Source files
------------

// File: rtl/gray_fifo_drain.sv
`timescale 1ns/1ps
// gray_fifo_drain: polls a bin2gray FIFO, pops gray words, decodes them
// to binary and streams them out through a 2-entry skid buffer.
module gray_fifo_drain #(
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int POLL_GAP = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          bus_enable,
    output logic [1:0]    bus_addr,
    output logic          bus_read,
    output logic          bus_write,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [7:0]    err_cnt,
    output logic          busy
);

    localparam int GW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP);
    localparam logic [DW-1:0] CLR_WORD = DW'(8'h10);
    localparam bit LAT0 = (RD_LAT == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAT,
        S_POP,
        S_WAIT,
        S_CLR
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    err_q, err_d;
    logic [DW-1:0] slot0_q, slot1_q;
    logic [1:0]    occ_q, occ_d;
    logic          push, pop, inflight;
    logic          has_credit, room_after;
    logic [DW-1:0] dec_data;
    logic          en_d, rd_d, wr_d;
    logic [1:0]    addr_d;
    logic [DW-1:0] wd_d;

    function automatic logic [DW-1:0] gray2bin(input logic [DW-1:0] g);
        logic [DW-1:0] b;
        b[DW-1] = g[DW-1];
        for (int i = DW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign dec_data   = gray2bin(bus_rdata);
    assign push       = LAT0 ? (state_q == S_POP) : (state_q == S_WAIT);
    assign pop        = m_valid && m_ready;
    assign inflight   = (state_q == S_POP) || (state_q == S_WAIT);
    assign has_credit = ({1'b0, occ_q} + {2'b0, inflight}) < 3'd2;
    assign room_after = occ_d < 2'd2;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = slot0_q;
    assign err_cnt = err_q;
    assign busy    = (state_q != S_IDLE) || (occ_q != 2'd0);

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (!push && pop) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Head always lives in slot0; a simultaneous push/pop shifts through.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            occ_q <= occ_d;
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0_q <= dec_data;
                    end else begin
                        slot1_q <= dec_data;
                    end
                end
                2'b01: slot0_q <= slot1_q;
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        slot0_q <= dec_data;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= dec_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (has_credit && gap_q == '0) begin
                    state_d = S_STAT;
                end else if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_STAT: begin
                if (bus_rdata[3] | bus_rdata[2]) begin
                    state_d = S_CLR;
                end else if (bus_rdata[0]) begin
                    state_d = S_IDLE;
                    gap_d   = GAP_LOAD;
                end else if (has_credit) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                if (!LAT0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = room_after ? S_STAT : S_IDLE;
                end
            end
            S_WAIT: state_d = room_after ? S_STAT : S_IDLE;
            S_CLR: begin
                state_d = S_IDLE;
                gap_d   = GAP_LOAD;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they line up
    // with the cycle the FSM spends in that state.
    always_comb begin
        en_d   = 1'b0;
        addr_d = 2'd0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        wd_d   = '0;
        unique case (state_d)
            S_STAT: begin
                en_d   = 1'b1;
                addr_d = 2'd3;
                rd_d   = 1'b1;
            end
            S_POP: begin
                en_d = 1'b1;
                rd_d = 1'b1;
            end
            S_CLR: begin
                en_d   = 1'b1;
                addr_d = 2'd3;
                wr_d   = 1'b1;
                wd_d   = CLR_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            err_q      <= '0;
            bus_enable <= 1'b0;
            bus_addr   <= 2'd0;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            bus_enable <= en_d;
            bus_addr   <= addr_d;
            bus_read   <= rd_d;
            bus_write  <= wr_d;
            bus_wdata  <= wd_d;
        end
    end

endmodule

// File: tb/tb_gray_fifo_drain.sv
`timescale 1ns/1ps
// Bench for gray_fifo_drain: models the bin2gray FIFO slave and checks
// the decoded stream against a scoreboard of expected binary words.
module tb_gray_fifo_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_enable, bus_read, bus_write;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       m_valid, m_ready, busy;
    logic [7:0] m_data, err_cnt;

    int tests = 0;
    int fails = 0;

    gray_fifo_drain dut (
        .clk(clk), .rst(rst),
        .bus_enable(bus_enable), .bus_addr(bus_addr),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO slave model (depth 8) and scoreboard
    logic [7:0] slv_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         hs_t[$];
    int         stat_t[$];
    int         slv_n = 0;
    bit         ovf = 0, udf = 0;
    logic [7:0] rd_hold = '0;
    logic [7:0] last_wdata = '0;
    int         cyc = 0, rd0_cnt = 0, wr_cnt = 0;

    assign bus_rdata = (bus_enable && bus_read && bus_addr == 2'd3) ?
        {4'b0, udf, ovf, slv_n == 8, slv_n == 0} : rd_hold;

    function automatic logic [7:0] ref_dec(input logic [7:0] g);
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++) b ^= (g >> k);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [7:0] g);
        if (slv_q.size() >= 8) begin
            ovf = 1'b1;
        end else begin
            slv_q.push_back(g);
            exp_q.push_back(ref_dec(g));
        end
        slv_n = slv_q.size();
    endtask

    always @(posedge clk) begin
        if (bus_enable && bus_read && bus_addr == 2'd0) begin
            rd0_cnt++;
            if (slv_q.size() > 0) begin
                rd_hold <= slv_q.pop_front();
            end else begin
                udf = 1'b1;
                rd_hold <= '0;
            end
        end
        if (bus_enable && bus_read && bus_addr == 2'd3) stat_t.push_back(cyc);
        if (bus_enable && bus_write && bus_addr == 2'd3) begin
            wr_cnt++;
            last_wdata = bus_wdata;
            if (bus_wdata[4]) begin
                ovf = 1'b0;
                udf = 1'b0;
                repeat (slv_q.size()) void'(exp_q.pop_back());
                slv_q.delete();
            end
        end
        slv_n = slv_q.size();
        cyc++;
    end

    // Stream monitor, sampled mid low phase
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_stall = 0;
        end else begin
            tests++;
            assert (!(bus_read && bus_write)) else begin
                fails++;
                $error("FAIL rd_wr_excl: got rd=%0b wr=%0b expected not both",
                       bus_read, bus_write);
            end
            if (prev_stall && m_valid) begin
                tests++;
                assert (m_data === prev_data) else begin
                    fails++;
                    $error("FAIL stall_stable: got %0h expected %0h",
                           m_data, prev_data);
                end
            end
            if (m_valid && m_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $error("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    assert (m_data === e) else begin
                        fails++;
                        $error("FAIL m_data: got %0h expected %0h", m_data, e);
                    end
                end
                got_q.push_back(m_data);
                hs_t.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic wait_drain(input int maxc, input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_clear(output bit ok);
        int w0 = wr_cnt;
        int n = 0;
        while (wr_cnt == w0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (wr_cnt != w0);
        @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_en"}, bus_enable, 0);
        check({tag, "_addr"}, bus_addr, 0);
        check({tag, "_rd"}, bus_read, 0);
        check({tag, "_wr"}, bus_write, 0);
        check({tag, "_wdata"}, bus_wdata, 0);
        check({tag, "_mvalid"}, m_valid, 0);
        check({tag, "_mdata"}, m_data, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, r0, w0, nv, bad;
        bit ok;
        rst = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        check("rst_err", err_cnt, 0);
        rst = 1'b0;

        // decode of known words
        m_ready = 1'b1;
        got_q.delete();
        push_w(8'h0C); push_w(8'h80); push_w(8'h00);
        wait_drain(100, "t2_drain");
        check("t2_n", got_q.size(), 3);
        check("t2_w0", got_q[0], 8'h08);
        check("t2_w1", got_q[1], 8'hFF);
        check("t2_w2", got_q[2], 8'h00);

        // a full FIFO is not an error
        got_q.delete();
        for (int i = 0; i < 8; i++) push_w(8'($urandom));
        wait_drain(200, "full_drain");
        check("full_n", got_q.size(), 8);
        check("full_err", err_cnt, 0);

        // RD_LAT=1 throughput: one word per 3 cycles
        hs_t.delete();
        for (int i = 0; i < 4; i++) push_w(8'($urandom));
        wait_drain(100, "t6_drain");
        check("t6_n", hs_t.size(), 4);
        for (int i = 1; i < hs_t.size(); i++)
            check("t6_gap", hs_t[i] - hs_t[i-1], 3);

        // backpressure
        m_ready = 1'b0;
        r0 = rd0_cnt;
        n0 = got_q.size();
        for (int i = 0; i < 5; i++) push_w(8'($urandom));
        repeat (20) @(negedge clk);
        check("t3_reads", rd0_cnt - r0, 2);
        check("t3_valid", m_valid, 1);
        check("t3_busy", busy, 1);
        m_ready = 1'b1;
        wait_drain(100, "t3_drain");
        check("t3_n", got_q.size() - n0, 5);

        // empty polling cadence
        repeat (10) @(negedge clk);
        stat_t.delete();
        r0 = rd0_cnt;
        repeat (40) @(negedge clk);
        check("t4_pop", rd0_cnt - r0, 0);
        check("t4_cnt", stat_t.size() >= 9, 1);
        for (int i = 1; i < stat_t.size(); i++)
            check("t4_gap", stat_t[i] - stat_t[i-1], 4);

        // reset while waiting for read data
        push_w(8'h5A);
        n0 = 0;
        ok = 0;
        while (!ok && n0 < 50) begin
            @(negedge clk);
            #1;
            ok = bus_read && bus_addr == 2'd0;
            n0++;
        end
        check("t1_pop_seen", ok, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outs("t1");
        while (exp_q.size() > slv_q.size()) void'(exp_q.pop_front());
        rst = 1'b0;
        nv = 0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (m_valid) nv++;
        end
        check("t1_no_valid", nv, 0);

        // overflow -> clear, error count, saturation
        w0 = wr_cnt;
        for (int i = 0; i < 9; i++) push_w(8'($urandom));
        wait_clear(ok);
        check("t5_clr", ok, 1);
        check("t5_nwr", wr_cnt - w0, 1);
        check("t5_wdata", last_wdata, 8'h10);
        check("t5_err1", err_cnt, 1);
        check("t5_discard", exp_q.size(), 0);
        udf = 1'b1;
        wait_clear(ok);
        check("t5_udf_err", err_cnt, 2);
        bad = 0;
        for (int i = 0; i < 253; i++) begin
            for (int j = 0; j < 9; j++) push_w(8'($urandom));
            wait_clear(ok);
            if (!ok) bad++;
        end
        check("t5_timeouts", bad, 0);
        check("t5_sat", err_cnt, 8'hFF);
        for (int j = 0; j < 9; j++) push_w(8'($urandom));
        wait_clear(ok);
        check("t5_sat_clr", ok, 1);
        check("t5_sat_hold", err_cnt, 8'hFF);

        // randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && slv_q.size() < 8)
                push_w(8'($urandom));
        end
        m_ready = 1'b1;
        wait_drain(300, "rand_drain");
        check("rand_err", err_cnt, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
